// File: rtl/jt6295_rom_sched.sv
// Four-voice ROM fetch scheduler for the JT6295 ADPCM core.
// It rotates a voice slot on every cen_sr4 pulse and fetches one ROM byte in each busy voice's slot.
// It delivers one nibble per fetch to the decoder and keeps each voice's address, end address and busy state.
module jt6295_rom_sched #(
    parameter int unsigned AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_sr4,
    input  logic          cen_sr,
    input  logic [3:0]    start,
    input  logic [3:0]    stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [7:0]    rom_data,
    output logic [3:0]    nib,
    output logic [1:0]    nib_ch,
    output logic          nib_valid,
    output logic          nib_miss,
    output logic [3:0]    busy,
    output logic [3:0]    done
);

    localparam int unsigned NV = 4;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t        st;
    logic [1:0]    slot;
    logic [1:0]    ch;
    logic          miss;
    logic [CW-1:0] cur   [NV];
    logic [AW-1:0] end_q [NV];

    logic [1:0]    slot_nxt;
    logic [CW-1:0] cur_ch;
    logic          hit_end;
    logic          fetch_end;
    logic          deliver;

    // Next slot index and per-fetch decode of the active voice
    always_comb begin
        slot_nxt  = cen_sr ? 2'd0 : slot + 2'd1;
        cur_ch    = cur[ch];
        hit_end   = cur_ch[0] && (cur_ch[CW-1:1] == end_q[ch]);
        fetch_end = (st == S_WAIT) && rom_ok;
        deliver   = busy[ch] && !stop[ch];
    end

    // Slot rotation, shared fetch FSM and per-voice state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= 2'd0;
            ch        <= 2'd0;
            st        <= S_IDLE;
            miss      <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            nib       <= 4'd0;
            nib_ch    <= 2'd0;
            nib_valid <= 1'b0;
            nib_miss  <= 1'b0;
            busy      <= 4'd0;
            done      <= 4'd0;
            for (int i = 0; i < int'(NV); i++) begin
                cur[i]   <= '0;
                end_q[i] <= '0;
            end
        end else begin
            nib_valid <= 1'b0;
            nib_miss  <= 1'b0;
            done      <= 4'd0;

            if (cen_sr4) begin
                slot <= slot_nxt;
            end

            case (st)
                S_IDLE: begin
                    // The slot tested is the one loaded by this pulse
                    if (cen_sr4 && busy[slot_nxt]) begin
                        ch       <= slot_nxt;
                        rom_addr <= cur[slot_nxt][CW-1:1];
                        rom_cs   <= 1'b1;
                        miss     <= 1'b0;
                        st       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A slot pulse arriving mid-fetch is lost; flag the late nibble
                    if (cen_sr4) begin
                        miss <= 1'b1;
                    end
                    if (rom_ok) begin
                        rom_cs    <= 1'b0;
                        nib       <= cur_ch[0] ? rom_data[3:0] : rom_data[7:4];
                        nib_ch    <= ch;
                        nib_valid <= deliver;
                        nib_miss  <= deliver && (miss || cen_sr4);
                        if (deliver && hit_end) begin
                            done[ch] <= 1'b1;
                        end
                        cur[ch] <= cur_ch + CW'(1);
                        st      <= S_OUT;
                    end
                end
                S_OUT: begin
                    st <= S_IDLE;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase

            // Stop beats start; start only loads an idle voice; natural end clears busy
            for (int i = 0; i < int'(NV); i++) begin
                if (stop[i]) begin
                    busy[i] <= 1'b0;
                end else if (start[i] && !busy[i]) begin
                    busy[i]  <= 1'b1;
                    cur[i]   <= {start_addr, 1'b0};
                    end_q[i] <= end_addr;
                end else if (fetch_end && deliver && hit_end && (ch == 2'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt6295_rom_sched.sv
// Scoreboard bench for jt6295_rom_sched: a voice-level playback model predicts fetch addresses and nibbles.
module tb_jt6295_rom_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen_sr4, cen_sr;
    logic [3:0]  start, stop;
    logic [17:0] start_addr, end_addr;
    logic [17:0] rom_addr;
    logic        rom_cs, rom_ok;
    logic [7:0]  rom_data;
    logic [3:0]  nib;
    logic [1:0]  nib_ch;
    logic        nib_valid, nib_miss;
    logic [3:0]  busy, done;

    jt6295_rom_sched #(.AW(18)) dut (
        .clk(clk), .rst_n(rst_n), .cen_sr4(cen_sr4), .cen_sr(cen_sr),
        .start(start), .stop(stop), .start_addr(start_addr), .end_addr(end_addr),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .nib(nib), .nib_ch(nib_ch), .nib_valid(nib_valid), .nib_miss(nib_miss),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] nib;
        logic       miss;
        logic [3:0] done;
    } nev_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected nibble events and expected ROM requests
    nev_t        nq[$];
    int          cq[$];
    logic [17:0] aq[$];
    int          lq[$];
    int          acq[$];

    // Voice-level playback model
    logic [17:0] maddr [4];
    logic [17:0] mend  [4];
    logic [3:0]  mhalf;
    logic [3:0]  mbusy;
    int          pcount;
    bit          skip;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] rom_fn(input logic [17:0] a);
        if (a == 18'h00100) return 8'hA5;
        if (a == 18'h00101) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ {a[17:16], 6'h15};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ROM responder: acknowledges each request after its scheduled extra latency
    initial begin
        bit          active;
        int          wait_n;
        logic [17:0] ea;
        int          ecy;
        active   = 0;
        wait_n   = 0;
        rom_ok   = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            rom_ok = 1'b0;
            if (rom_cs) begin
                if (!active) begin
                    active = 1;
                    n_cmp++;
                    if (aq.size() == 0) begin
                        n_bad++;
                        wait_n = 0;
                        $display("FAIL unexpected_fetch got addr=%h cycle=%0d", rom_addr, cyc);
                    end else begin
                        ea     = aq.pop_front();
                        wait_n = lq.pop_front();
                        ecy    = acq.pop_front();
                        if (rom_addr !== ea || cyc != ecy) begin
                            n_bad++;
                            $display("FAIL rom_request got addr=%h cycle=%0d want addr=%h cycle=%0d",
                                     rom_addr, cyc, ea, ecy);
                        end
                    end
                end
                if (wait_n == 0) begin
                    rom_ok   = 1'b1;
                    rom_data = rom_fn(rom_addr);
                    active   = 0;
                end else begin
                    wait_n--;
                end
            end else begin
                active = 0;
            end
        end
    end

    // Monitor: every nibble pulse is popped against the scoreboard
    always @(negedge clk) begin
        nev_t e, g;
        int   ec;
        if (rst_n === 1'b1) begin
            g = {nib_ch, nib, nib_miss, done};
            if (nib_valid) begin
                n_cmp++;
                if (nq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_nib got ch=%0d nib=%h cycle=%0d", nib_ch, nib, cyc);
                end else begin
                    e  = nq.pop_front();
                    ec = cq.pop_front();
                    if (g !== e || cyc != ec) begin
                        n_bad++;
                        $display("FAIL nib_event got ch=%0d nib=%h miss=%b done=%b cyc=%0d want ch=%0d nib=%h miss=%b done=%b cyc=%0d",
                                 g.ch, g.nib, g.miss, g.done, cyc, e.ch, e.nib, e.miss, e.done, ec);
                    end
                end
            end else if (done !== 4'd0 || nib_miss !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_pulse got done=%b miss=%b want none", done, nib_miss);
            end
        end
    end

    // One sample-slot period of 8 cycles: cen_sr4 on cycle 0, mid-fetch stop on cycle 3, strobes on cycle sc
    task automatic period(input int lat, input logic [3:0] stop_mid, input int sc,
                          input logic [3:0] st_v, input logic [3:0] sp_v,
                          input logic [17:0] sa, input logic [17:0] ea, input bit chk_busy);
        int         s;
        logic [7:0] b;
        nev_t       e;
        bit         dn;
        s       = pcount % 4;
        cen_sr4 = 1'b1;
        cen_sr  = (s == 0);
        if (skip) begin
            skip = 0;
        end else if (mbusy[s]) begin
            aq.push_back(maddr[s]);
            lq.push_back(lat);
            acq.push_back(cyc + 1);
            b  = rom_fn(maddr[s]);
            dn = mhalf[s] && (maddr[s] == mend[s]);
            if (!stop_mid[s]) begin
                e.ch   = 2'(s);
                e.nib  = mhalf[s] ? b[3:0] : b[7:4];
                e.miss = (lat > 6);
                e.done = dn ? (4'b0001 << s) : 4'b0000;
                nq.push_back(e);
                cq.push_back(cyc + 2 + lat);
                if (mhalf[s]) begin
                    maddr[s] = maddr[s] + 18'd1;
                    mhalf[s] = 1'b0;
                end else begin
                    mhalf[s] = 1'b1;
                end
                if (dn) mbusy[s] = 1'b0;
            end
            if (lat > 6) skip = 1;
        end
        pcount++;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin
                stop  = stop_mid;
                mbusy = mbusy & ~stop_mid;
            end
            if (c == sc) begin
                start      = st_v;
                stop       = stop | sp_v;
                start_addr = sa;
                end_addr   = ea;
                for (int i = 0; i < 4; i++) begin
                    if (sp_v[i]) begin
                        mbusy[i] = 1'b0;
                    end else if (st_v[i] && !mbusy[i]) begin
                        mbusy[i] = 1'b1;
                        maddr[i] = sa;
                        mend[i]  = ea;
                        mhalf[i] = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1;
            cen_sr4 = 1'b0;
            cen_sr  = 1'b0;
            start   = 4'd0;
            stop    = 4'd0;
        end
        if (chk_busy) chk("busy", 32'(busy), 32'(mbusy));
    endtask

    task automatic idle_period(input int lat);
        period(lat, 4'd0, 6, 4'd0, 4'd0, 18'd0, 18'd0, 1);
    endtask

    task automatic run_to_slot(input int s);
        for (int k = 0; k < 4 && (pcount % 4) != s; k++) idle_period(int'($urandom_range(0, 3)));
    endtask

    task automatic model_reset();
        mbusy  = 4'd0;
        mhalf  = 4'd0;
        pcount = 0;
        skip   = 0;
        for (int i = 0; i < 4; i++) begin
            maddr[i] = 18'd0;
            mend[i]  = 18'd0;
        end
        nq.delete(); cq.delete(); aq.delete(); lq.delete(); acq.delete();
    endtask

    initial begin
        logic [3:0]  st_v, sp_v;
        logic [17:0] sa, ea;
        int          lat;
        rst_n      = 1'b0;
        cen_sr4    = 1'b0;
        cen_sr     = 1'b0;
        start      = 4'd0;
        stop       = 4'd0;
        start_addr = 18'd0;
        end_addr   = 18'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_rom_cs",    32'(rom_cs),    32'd0);
        chk("rst_rom_addr",  32'(rom_addr),  32'd0);
        chk("rst_nib",       32'(nib),       32'd0);
        chk("rst_nib_ch",    32'(nib_ch),    32'd0);
        chk("rst_nib_valid", 32'(nib_valid), 32'd0);
        chk("rst_nib_miss",  32'(nib_miss),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);

        // Single voice, zero-wait ROM: nibbles A,5,3,C then done
        period(0, 4'd0, 6, 4'b0001, 4'd0, 18'h00100, 18'h00101, 1);
        for (int k = 0; k < 17; k++) idle_period(0);
        chk("single_voice_idle", 32'(busy[0]), 32'd0);

        // All four voices, long samples
        for (int v = 0; v < 4; v++)
            period(int'($urandom_range(0, 3)), 4'd0, 6, 4'(1 << v), 4'd0,
                   18'h02000 + 18'(v * 18'h40), 18'h02020 + 18'(v * 18'h40), 1);
        for (int k = 0; k < 8; k++) idle_period(int'($urandom_range(0, 3)));

        // Restart of a busy voice is ignored
        period(1, 4'd0, 6, 4'b0100, 4'd0, 18'h15555, 18'h15556, 1);
        for (int k = 0; k < 4; k++) idle_period(int'($urandom_range(0, 3)));

        // Slow ROM on slot 2: late nibble flagged, slot 3 skipped
        run_to_slot(2);
        period(9, 4'd0, 6, 4'd0, 4'd0, 18'd0, 18'd0, 0);
        for (int k = 0; k < 6; k++) idle_period(int'($urandom_range(0, 3)));

        // Stop voice 2 while its fetch is waiting on a 5-cycle ROM
        run_to_slot(2);
        period(5, 4'b0100, 6, 4'd0, 4'd0, 18'd0, 18'd0, 1);
        for (int k = 0; k < 4; k++) idle_period(int'($urandom_range(0, 3)));

        // Stop voice 1, then simultaneous start and stop keeps it idle
        period(0, 4'd0, 6, 4'd0, 4'b0010, 18'd0, 18'd0, 1);
        period(0, 4'd0, 6, 4'b0010, 4'b0010, 18'h00300, 18'h00301, 1);
        chk("start_stop_idle", 32'(busy[1]), 32'd0);

        // Start landing on the voice's own slot pulse is not fetched in that slot
        run_to_slot(1);
        period(0, 4'd0, 0, 4'b0010, 4'd0, 18'h00400, 18'h00400, 1);
        for (int k = 0; k < 8; k++) idle_period(int'($urandom_range(0, 3)));
        period(0, 4'd0, 6, 4'd0, 4'b1111, 18'd0, 18'd0, 1);

        // Address wrap at the top of the ROM
        period(0, 4'd0, 6, 4'b1000, 4'd0, 18'h3FFFF, 18'h00000, 1);
        for (int k = 0; k < 20; k++) idle_period(int'($urandom_range(0, 3)));
        chk("wrap_idle", 32'(busy[3]), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                period(9, 4'd0, 6, 4'd0, 4'd0, 18'd0, 18'd0, 0);
            end else begin
                lat  = int'($urandom_range(0, 3));
                st_v = 4'd0;
                sp_v = 4'd0;
                if ($urandom_range(0, 1) == 1) st_v = 4'b0001 << $urandom_range(0, 3);
                if ($urandom_range(0, 15) == 0) sp_v = 4'($urandom_range(0, 15));
                sa = 18'($urandom);
                ea = sa + 18'($urandom_range(0, 3));
                period(lat, 4'd0, 6, st_v, sp_v, sa, ea, 1);
            end
        end

        // Reset in the middle of a fetch
        period(0, 4'd0, 6, 4'd0, 4'b1111, 18'd0, 18'd0, 1);
        run_to_slot(3);
        period(0, 4'd0, 6, 4'b0001, 4'd0, 18'h00555, 18'h00560, 1);
        cen_sr4 = 1'b1;
        cen_sr  = 1'b1;
        aq.push_back(maddr[0]);
        lq.push_back(20);
        acq.push_back(cyc + 1);
        pcount++;
        @(posedge clk);
        #1 cen_sr4 = 1'b0;
        cen_sr = 1'b0;
        @(posedge clk);
        #1;
        chk("rom_cs_waiting", 32'(rom_cs), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_async_busy",   32'(busy),   32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 rom_ok = 1'b1;
        rom_data = 8'hFF;
        @(posedge clk);
        #2 rom_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_rom_cs", 32'(rom_cs), 32'd0);

        // Normal operation after reset
        period(0, 4'd0, 6, 4'b0100, 4'd0, 18'h01234, 18'h01235, 1);
        for (int k = 0; k < 20; k++) idle_period(int'($urandom_range(0, 3)));

        repeat (10) @(posedge clk);
        #1;
        chk("nib_queue_empty", 32'(nq.size()), 32'd0);
        chk("rom_queue_empty", 32'(aq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
